// File: rtl/ctrl_pkg.sv
// Shared types and constants for the D-stage stall logic.
// Holds the use-time and Tnew encodings plus the scoreboard entry layout.
package ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_PC   = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LD   = 2'd2;

  typedef struct packed {
    logic       we;
    logic [4:0] a3;
    logic [1:0] tnew;
  } sb_entry_t;

  // One pipeline stage closer to the result; Tnew bottoms out at zero
  function automatic sb_entry_t age_entry(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    r.tnew = (e.tnew == TNEW_PC) ? TNEW_PC : e.tnew - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/ctrl_hazard_cmp.sv
// Compares one D-stage source operand against the E and M scoreboard entries.
// E is the younger producer, so when it matches its Tnew alone decides.
module ctrl_hazard_cmp
  import ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  sb_entry_t  entry_e,
  input  sb_entry_t  entry_m,
  output logic       hazard
);

  logic match_e;
  logic match_m;

  assign match_e = entry_e.we && (entry_e.a3 == src);
  assign match_m = entry_m.we && (entry_m.a3 == src);

  always_comb begin
    hazard = 1'b0;
    if (src != 5'd0 && tuse != TUSE_NONE) begin
      if (match_e)
        hazard = (tuse < entry_e.tnew);
      else if (match_m)
        hazard = (tuse < entry_m.tnew);
    end
  end

endmodule

// File: rtl/ctrl_stall_scoreboard.sv
// Stall side of the data-hazard protocol: tracks producers in E and M and
// freezes F/D (injecting an E bubble) whenever forwarding cannot help yet.
module ctrl_stall_scoreboard
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       Tuse_rs,
  input  logic [1:0]       Tuse_rt,
  input  logic [4:0]       SPL_rs,
  input  logic [4:0]       SPL_rt,
  input  logic             GRFWE_D,
  input  logic [4:0]       GRF_A3_D,
  input  logic [1:0]       Tnew_D,
  input  logic             MD_D,
  input  logic             MDU_Start_E,
  input  logic             MDU_Busy,
  input  logic             Flush,
  output logic             Stall,
  output logic             GRFWE_E,
  output logic             GRFWE_M,
  output logic [4:0]       GRF_A3_E,
  output logic [4:0]       GRF_A3_M,
  output logic [1:0]       Tnew_E,
  output logic [1:0]       Tnew_M,
  output logic [CNT_W-1:0] Stall_Cnt
);

  sb_entry_t ent_e;
  sb_entry_t ent_m;
  sb_entry_t ent_d;
  logic      hazard_rs;
  logic      hazard_rt;
  logic      hazard_mdu;

  assign ent_d = '{we: GRFWE_D, a3: GRF_A3_D, tnew: Tnew_D};

  ctrl_hazard_cmp u_cmp_rs (
    .src     (SPL_rs),
    .tuse    (Tuse_rs),
    .entry_e (ent_e),
    .entry_m (ent_m),
    .hazard  (hazard_rs)
  );

  ctrl_hazard_cmp u_cmp_rt (
    .src     (SPL_rt),
    .tuse    (Tuse_rt),
    .entry_e (ent_e),
    .entry_m (ent_m),
    .hazard  (hazard_rt)
  );

  assign hazard_mdu = MD_D && (MDU_Busy || MDU_Start_E);
  assign Stall      = hazard_rs || hazard_rt || hazard_mdu;

  // Flush beats stall; a stalled cycle still lets the old E move into M
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_e <= '0;
      ent_m <= '0;
    end else if (Flush) begin
      ent_e <= '0;
      ent_m <= '0;
    end else if (Stall) begin
      ent_e <= '0;
      ent_m <= age_entry(ent_e);
    end else begin
      ent_e <= ent_d;
      ent_m <= age_entry(ent_e);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      Stall_Cnt <= '0;
    else if (Stall && !Flush && Stall_Cnt != {CNT_W{1'b1}})
      Stall_Cnt <= Stall_Cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign GRFWE_E  = ent_e.we;
  assign GRF_A3_E = ent_e.a3;
  assign Tnew_E   = ent_e.tnew;
  assign GRFWE_M  = ent_m.we;
  assign GRF_A3_M = ent_m.a3;
  assign Tnew_M   = ent_m.tnew;

endmodule

// File: tb/tb_ctrl_stall_scoreboard.sv
// Directed self-checking bench for ctrl_stall_scoreboard.
// Uses a 4-bit counter instance so saturation is reachable in a few cycles.
module tb_ctrl_stall_scoreboard;
  import ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [1:0]    Tuse_rs, Tuse_rt;
  logic [4:0]    SPL_rs, SPL_rt;
  logic          GRFWE_D;
  logic [4:0]    GRF_A3_D;
  logic [1:0]    Tnew_D;
  logic          MD_D, MDU_Start_E, MDU_Busy, Flush;
  logic          Stall;
  logic          GRFWE_E, GRFWE_M;
  logic [4:0]    GRF_A3_E, GRF_A3_M;
  logic [1:0]    Tnew_E, Tnew_M;
  logic [CW-1:0] Stall_Cnt;

  int checks;
  int failures;

  ctrl_stall_scoreboard #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Tuse_rs     (Tuse_rs),
    .Tuse_rt     (Tuse_rt),
    .SPL_rs      (SPL_rs),
    .SPL_rt      (SPL_rt),
    .GRFWE_D     (GRFWE_D),
    .GRF_A3_D    (GRF_A3_D),
    .Tnew_D      (Tnew_D),
    .MD_D        (MD_D),
    .MDU_Start_E (MDU_Start_E),
    .MDU_Busy    (MDU_Busy),
    .Flush       (Flush),
    .Stall       (Stall),
    .GRFWE_E     (GRFWE_E),
    .GRFWE_M     (GRFWE_M),
    .GRF_A3_E    (GRF_A3_E),
    .GRF_A3_M    (GRF_A3_M),
    .Tnew_E      (Tnew_E),
    .Tnew_M      (Tnew_M),
    .Stall_Cnt   (Stall_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_d();
    Tuse_rs = TUSE_NONE; Tuse_rt = TUSE_NONE;
    SPL_rs = 5'd0; SPL_rt = 5'd0;
    GRFWE_D = 1'b0; GRF_A3_D = 5'd0; Tnew_D = 2'd0;
    MD_D = 1'b0; MDU_Start_E = 1'b0; MDU_Busy = 1'b0; Flush = 1'b0;
  endtask

  task automatic producer(input logic [4:0] a3, input logic [1:0] tnew);
    idle_d();
    GRFWE_D = 1'b1; GRF_A3_D = a3; Tnew_D = tnew;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_d();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0 || Stall_Cnt !== '0 || GRFWE_E !== 1'b0 || GRFWE_M !== 1'b0 ||
        GRF_A3_E !== 5'd0 || GRF_A3_M !== 5'd0 || Tnew_E !== 2'd0 || Tnew_M !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: stall=%b cnt=%0d weE=%b weM=%b a3E=%0d a3M=%0d tE=%0d tM=%0d, required all 0",
               Stall, Stall_Cnt, GRFWE_E, GRFWE_M, GRF_A3_E, GRF_A3_M, Tnew_E, Tnew_M);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    producer(5'd3, TNEW_LD);
    #1;
    checks++;
    if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL lu_pre: stall=%b required 0", Stall); end
    step();
    producer(5'd4, TNEW_ALU);
    SPL_rs = 5'd3; Tuse_rs = 2'd1;
    #1;
    checks++;
    if (Stall !== 1'b1 || GRF_A3_E !== 5'd3 || Tnew_E !== 2'd2) begin
      failures++;
      $display("[TB] FAIL lu_stall: stall=%b a3E=%0d tE=%0d required 1/3/2", Stall, GRF_A3_E, Tnew_E);
    end
    step();
    checks++;
    if (Stall !== 1'b0 || GRFWE_E !== 1'b0 || GRFWE_M !== 1'b1 || GRF_A3_M !== 5'd3 ||
        Tnew_M !== 2'd1 || Stall_Cnt !== 4'd1) begin
      failures++;
      $display("[TB] FAIL lu_release: stall=%b weE=%b weM=%b a3M=%0d tM=%0d cnt=%0d required 0/0/1/3/1/1",
               Stall, GRFWE_E, GRFWE_M, GRF_A3_M, Tnew_M, Stall_Cnt);
    end
    step();
    checks++;
    if (GRFWE_E !== 1'b1 || GRF_A3_E !== 5'd4 || Tnew_E !== 2'd1 || GRFWE_M !== 1'b0 || Stall_Cnt !== 4'd1) begin
      failures++;
      $display("[TB] FAIL lu_advance: weE=%b a3E=%0d tE=%0d weM=%b cnt=%0d required 1/4/1/0/1",
               GRFWE_E, GRF_A3_E, Tnew_E, GRFWE_M, Stall_Cnt);
    end
  endtask

  task automatic test_branch_alu();
    do_reset();
    producer(5'd5, TNEW_ALU);
    step();
    idle_d();
    SPL_rs = 5'd5; Tuse_rs = 2'd0; SPL_rt = 5'd6; Tuse_rt = 2'd0;
    #1;
    checks++;
    if (Stall !== 1'b1) begin failures++; $display("[TB] FAIL br_stall: stall=%b required 1", Stall); end
    step();
    checks++;
    if (Stall !== 1'b0 || Tnew_M !== 2'd0 || GRF_A3_M !== 5'd5) begin
      failures++;
      $display("[TB] FAIL br_release: stall=%b tM=%0d a3M=%0d required 0/0/5", Stall, Tnew_M, GRF_A3_M);
    end
  endtask

  task automatic test_e_priority();
    do_reset();
    producer(5'd5, TNEW_LD);
    step();
    producer(5'd5, TNEW_PC);
    step();
    idle_d();
    SPL_rs = 5'd5; Tuse_rs = 2'd0;
    #1;
    checks++;
    if (Stall !== 1'b0 || Tnew_M !== 2'd1 || Tnew_E !== 2'd0) begin
      failures++;
      $display("[TB] FAIL e_priority: stall=%b tE=%0d tM=%0d required 0/0/1", Stall, Tnew_E, Tnew_M);
    end
  endtask

  task automatic test_rt_from_m();
    do_reset();
    producer(5'd9, TNEW_LD);
    step();
    idle_d();
    step();
    SPL_rt = 5'd9; Tuse_rt = 2'd0;
    #1;
    checks++;
    if (Stall !== 1'b1) begin failures++; $display("[TB] FAIL rt_m_stall: stall=%b required 1", Stall); end
    step();
    checks++;
    if (Stall !== 1'b0 || GRFWE_M !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rt_m_release: stall=%b weM=%b required 0/0", Stall, GRFWE_M);
    end
  endtask

  task automatic test_zero_unused();
    do_reset();
    producer(5'd0, TNEW_LD);
    step();
    idle_d();
    SPL_rs = 5'd0; Tuse_rs = 2'd0;
    #1;
    checks++;
    if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL zero_reg: stall=%b required 0", Stall); end
    producer(5'd7, TNEW_LD);
    step();
    idle_d();
    SPL_rt = 5'd7; Tuse_rt = TUSE_NONE;
    #1;
    checks++;
    if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL unused_rt: stall=%b required 0", Stall); end
    Tuse_rt = 2'd1;
    #1;
    checks++;
    if (Stall !== 1'b1) begin failures++; $display("[TB] FAIL used_rt: stall=%b required 1", Stall); end
  endtask

  task automatic test_mdu();
    int stalled;
    do_reset();
    idle_d();
    MD_D = 1'b1; GRFWE_D = 1'b1; GRF_A3_D = 5'd8; Tnew_D = TNEW_ALU;
    MDU_Start_E = 1'b1;
    stalled = 0;
    #1;
    if (Stall === 1'b1) stalled++;
    step();
    MDU_Start_E = 1'b0;
    MDU_Busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (Stall === 1'b1) stalled++;
      step();
    end
    MDU_Busy = 1'b0;
    #1;
    checks++;
    if (stalled != 6) begin failures++; $display("[TB] FAIL mdu_stall_cycles: got %0d required 6", stalled); end
    checks++;
    if (Stall !== 1'b0 || Stall_Cnt !== 4'd6) begin
      failures++;
      $display("[TB] FAIL mdu_release: stall=%b cnt=%0d required 0/6", Stall, Stall_Cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    producer(5'd3, TNEW_LD);
    step();
    producer(5'd4, TNEW_ALU);
    SPL_rs = 5'd3; Tuse_rs = 2'd1;
    Flush = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b1) begin failures++; $display("[TB] FAIL flush_pre: stall=%b required 1", Stall); end
    step();
    Flush = 1'b0;
    #1;
    checks++;
    if (GRFWE_E !== 1'b0 || GRF_A3_E !== 5'd0 || Tnew_E !== 2'd0 || GRFWE_M !== 1'b0 ||
        GRF_A3_M !== 5'd0 || Tnew_M !== 2'd0 || Stall_Cnt !== 4'd0 || Stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_clear: weE=%b a3E=%0d tE=%0d weM=%b a3M=%0d tM=%0d cnt=%0d stall=%b required all 0",
               GRFWE_E, GRF_A3_E, Tnew_E, GRFWE_M, GRF_A3_M, Tnew_M, Stall_Cnt, Stall);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    producer(5'd3, TNEW_LD);
    step();
    producer(5'd4, TNEW_ALU);
    SPL_rs = 5'd3; Tuse_rs = 2'd1;
    step();
    producer(5'd3, TNEW_LD);
    step();
    producer(5'd4, TNEW_ALU);
    SPL_rs = 5'd3; Tuse_rs = 2'd1;
    #1;
    checks++;
    if (Stall !== 1'b1 || Stall_Cnt !== 4'd1) begin
      failures++;
      $display("[TB] FAIL areset_pre: stall=%b cnt=%0d required 1/1", Stall, Stall_Cnt);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0 || Stall_Cnt !== 4'd0 || GRFWE_E !== 1'b0 || GRF_A3_E !== 5'd0 || Tnew_M !== 2'd0) begin
      failures++;
      $display("[TB] FAIL areset_now: stall=%b cnt=%0d weE=%b a3E=%0d tM=%0d required all 0",
               Stall, Stall_Cnt, GRFWE_E, GRF_A3_E, Tnew_M);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (Stall !== 1'b0 || Stall_Cnt !== 4'd0) begin
      failures++;
      $display("[TB] FAIL areset_after: stall=%b cnt=%0d required 0/0", Stall, Stall_Cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    idle_d();
    MD_D = 1'b1; MDU_Busy = 1'b1;
    for (int i = 0; i < 14; i++) step();
    checks++;
    if (Stall_Cnt !== 4'd14) begin failures++; $display("[TB] FAIL sat_preload: cnt=%0d required 14", Stall_Cnt); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (Stall_Cnt !== 4'd15) begin
        failures++;
        $display("[TB] FAIL sat_hold: cycle %0d cnt=%0d required 15", i, Stall_Cnt);
      end
    end
    idle_d();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle_d();
    test_reset();
    test_load_use();
    test_branch_alu();
    test_e_priority();
    test_rt_from_m();
    test_zero_unused();
    test_mdu();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
